io_input_conditioner: RTL and testbench

Conditions the raw DE2 board switches and pushbuttons before they reach the singlecycle core's `i_io_sw` / `i_io_btn` inputs. Every bit gets:

- a two-flop synchronizer,
- a per-bit consecutive-sample debouncer,
- polarity normalisation, so all outputs are active-high.

One-cycle press, release and change pulses are also produced for an optional edge-capture register in the LSU input page. The block sits between the top-level pins and the core; the core sees only the debounced levels.

---
 rtl/io_input_conditioner.sv | 88 ++++++++
 tb/tb_io_input_conditioner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// io_input_conditioner
// Synchronizes, debounces and polarity-normalises the board switches and
// pushbuttons. It also produces one-cycle press, release and switch-change
// pulses. Switches and buttons share one internal vector: switches occupy
// the low N_SW bits and buttons the high N_BTN bits.
module io_input_conditioner #(
    parameter int N_SW            = 32,
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SW-1:0]  i_sw_raw,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_SW-1:0]  o_io_sw,
    output logic [N_BTN-1:0] o_io_btn,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_release,
    output logic             o_sw_change
);

    localparam int N  = N_SW + N_BTN;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The count stops at this value, so the counter can never wrap.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     raw_norm;
    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    logic [N-1:0]     stable;
    logic [N-1:0]     upd;
    logic [CW-1:0]    cnt [N];
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic             sw_change_q;

    // The button inversion sits before the synchronizer, so everything
    // downstream of sync1 is active-high.
    assign raw_norm = {(BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw), i_sw_raw};

    // A bit accepts its new level when it disagrees with stable and has
    // already disagreed for DEBOUNCE_CYCLES-1 consecutive samples.
    always_comb begin
        upd = '0;
        for (int i = 0; i < N; i++) begin
            upd[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Synchronizer, per-bit debounce counters, stable levels and edge pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            press_q     <= '0;
            release_q   <= '0;
            sw_change_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_norm;
            sync2 <= sync1;
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (upd[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            press_q     <= upd[N-1:N_SW] & sync2[N-1:N_SW];
            release_q   <= upd[N-1:N_SW] & ~sync2[N-1:N_SW];
            sw_change_q <= |upd[N_SW-1:0];
        end
    end

    assign o_io_sw       = stable[N_SW-1:0];
    assign o_io_btn      = stable[N-1:N_SW];
    assign o_btn_press   = press_q;
    assign o_btn_release = release_q;
    assign o_sw_change   = sw_change_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner (DEBOUNCE_CYCLES=4, active-low
// buttons). The stimulus process pushes the hand-derived expected outputs
// for every clock edge. The monitor pops one entry per falling edge and
// compares it with the DUT outputs.
module tb_io_input_conditioner;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_sw_raw;
    logic [3:0]  i_btn_raw;
    logic [31:0] o_io_sw;
    logic [3:0]  o_io_btn;
    logic [3:0]  o_btn_press;
    logic [3:0]  o_btn_release;
    logic        o_sw_change;

    typedef struct packed {
        logic [31:0] sw;
        logic [3:0]  btn;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic        chg;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    int   cyc = 0;

    // Expected debounced levels as tracked by the stimulus process.
    logic [31:0] cur_sw = '0;
    logic [3:0]  cur_btn = '0;

    io_input_conditioner #(
        .N_SW(32), .N_BTN(4), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sw_raw(i_sw_raw), .i_btn_raw(i_btn_raw),
        .o_io_sw(o_io_sw), .o_io_btn(o_io_btn), .o_btn_press(o_btn_press),
        .o_btn_release(o_btn_release), .o_sw_change(o_sw_change)
    );

    always #5 i_clk = ~i_clk;

    // One clock edge, then record what the outputs must be after that edge.
    task automatic edge_push(input logic [31:0] sw, input logic [3:0] btn,
                             input logic [3:0] press, input logic [3:0] rel,
                             input logic chg);
        exp_t e;
        @(posedge i_clk);
        #1;
        e.sw = sw; e.btn = btn; e.press = press; e.rel = rel; e.chg = chg;
        q.push_back(e);
        n_pushed++;
    endtask

    // Hold the current levels with no pulses for n edges.
    task automatic hold(input int n);
        for (int k = 0; k < n; k++) edge_push(cur_sw, cur_btn, 4'h0, 4'h0, 1'b0);
    endtask

    // Drive new pins. The new level appears on the sixth edge, which is
    // 2 synchronizer edges plus 4 debounce samples. The caller states the
    // expected new levels; the pulses follow from old versus new levels.
    task automatic change(input logic [31:0] sw_pins, input logic [3:0] btn_pins,
                          input logic [31:0] new_sw, input logic [3:0] new_btn);
        i_sw_raw  = sw_pins;
        i_btn_raw = btn_pins;
        hold(5);
        edge_push(new_sw, new_btn, new_btn & ~cur_btn, ~new_btn & cur_btn,
                  new_sw != cur_sw);
        cur_sw  = new_sw;
        cur_btn = new_btn;
        hold(1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare one scoreboard entry per falling edge.
    always @(negedge i_clk) begin
        cyc++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_popped++;
            chk("io_sw",       o_io_sw,                e.sw);
            chk("io_btn",      {28'h0, o_io_btn},      {28'h0, e.btn});
            chk("btn_press",   {28'h0, o_btn_press},   {28'h0, e.press});
            chk("btn_release", {28'h0, o_btn_release}, {28'h0, e.rel});
            chk("sw_change",   {31'h0, o_sw_change},   {31'h0, e.chg});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with the switches up and the buttons held. The held levels
        // are acquired through the normal path after release.
        i_rst = 1'b1; i_sw_raw = 32'hFFFF_FFFF; i_btn_raw = 4'h0;
        hold(3);
        i_rst = 1'b0;
        change(32'hFFFF_FFFF, 4'h0, 32'hFFFF_FFFF, 4'hF);

        // Return to idle: all released, all switches down.
        change(32'h0, 4'hF, 32'h0, 4'h0);

        // Clean switch load, then back to zero.
        change(32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 4'h0);
        change(32'h0, 4'hF, 32'h0, 4'h0);

        // A 3-cycle glitch on sw[5] is rejected.
        i_sw_raw = 32'h20; hold(3);
        i_sw_raw = 32'h0;  hold(8);

        // A 4-cycle pulse on sw[5] is accepted. It rises at edge 6 and
        // falls 6 edges after the raw fall, which is edge 10 overall.
        i_sw_raw = 32'h20; hold(4);
        i_sw_raw = 32'h0;  hold(1);
        edge_push(32'h20, 4'h0, 4'h0, 4'h0, 1'b1);
        cur_sw = 32'h20;
        hold(3);
        edge_push(32'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        cur_sw = 32'h0;
        hold(2);

        // Bouncing press on button 0: low 3, high 1, then low steady.
        i_btn_raw = 4'hE; hold(3);
        i_btn_raw = 4'hF; hold(1);
        change(32'h0, 4'hE, 32'h0, 4'h1);
        change(32'h0, 4'hF, 32'h0, 4'h0);

        // Buttons 0 and 2 pressed together, then released together.
        change(32'h0, 4'hA, 32'h0, 4'h5);
        change(32'h0, 4'hF, 32'h0, 4'h0);

        // Reset mid-count discards progress. The level appears 6 edges
        // after reset release.
        i_sw_raw = 32'h0000_1234; hold(3);
        i_rst = 1'b1; hold(1);
        i_rst = 1'b0;
        change(32'h0000_1234, 4'hF, 32'h0000_1234, 4'h0);

        @(negedge i_clk);
        @(negedge i_clk);
        chk("scoreboard_drain", n_popped, n_pushed);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
